regfile_ctrl: RTL and testbench

Sequencer and arbiter for the EBR-backed CPU register file (64 x 32, write port plus two read ports, falling-edge read clock). It sits between the core's register-file ports and the register-file instance. After reset it clears all 64 entries, then passes core traffic through. It also grants a debug requester single-word read/write access by stalling the core for the duration.

---
 rtl/regfile_ctrl_if.sv | 36 +++
 rtl/regfile_ctrl.sv | 137 +++++++++++++
 tb/tb_regfile_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_if.sv
// Core, debug and register-file signal bundle around regfile_ctrl.
// master = core/debug/register-file side, slave = the controller.
interface regfile_ctrl_if;
   logic        cpu_wen;
   logic [5:0]  cpu_waddr;
   logic [31:0] cpu_wdata;
   logic [5:0]  cpu_raddr1;
   logic        cpu_stall;
   logic        rf_wen;
   logic [5:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [5:0]  rf_raddr1;
   logic [31:0] rf_rdata1;
   logic        dbg_req;
   logic        dbg_we;
   logic [5:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_ack;
   logic [31:0] dbg_rdata;

   modport master (
      output cpu_wen, cpu_waddr, cpu_wdata, cpu_raddr1,
      output rf_rdata1,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  cpu_stall, rf_wen, rf_waddr, rf_wdata, rf_raddr1,
      input  dbg_ack, dbg_rdata
   );

   modport slave (
      input  cpu_wen, cpu_waddr, cpu_wdata, cpu_raddr1,
      input  rf_rdata1,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output cpu_stall, rf_wen, rf_waddr, rf_wdata, rf_raddr1,
      output dbg_ack, dbg_rdata
   );
endinterface

// File: rtl/regfile_ctrl.sv
// Register-file sequencer: post-reset clear, core pass-through, debug access.
// Define REGFILE_CTRL_INIT_EN to include the post-reset clear sequence.
module regfile_ctrl #(
   parameter int NUM_REGS = 64
) (
   input logic           clk,
   input logic           rst,
   regfile_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      STALL,
      ACCESS,
      ACK
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        stall_nxt;
   logic        init_done;
   logic [5:0]  cnt;
   logic        lat_we;
   logic [5:0]  lat_addr;
   logic [31:0] lat_wdata;
   logic        stall_q;
   logic [31:0] rdata_q;

`ifdef REGFILE_CTRL_INIT_EN
   localparam state_t     RST_STATE = INIT;
   localparam logic       RST_STALL = 1'b1;
   localparam logic [5:0] LAST      = 6'(NUM_REGS - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (state == INIT)
         cnt <= cnt + 6'd1;
      else
         cnt <= '0;
   end

   assign init_done = (cnt == LAST);
`else
   localparam state_t RST_STATE = IDLE;
   localparam logic   RST_STALL = 1'b0;
   localparam int     unused_num_regs = NUM_REGS;

   assign cnt       = '0;
   assign init_done = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RST_STATE;
         stall_q <= RST_STALL;
      end else begin
         state   <= state_nxt;
         stall_q <= stall_nxt;
      end
   end

   // Debug fields are captured on the grant so later input changes are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (state == IDLE && bus.dbg_req) begin
         lat_we    <= bus.dbg_we;
         lat_addr  <= bus.dbg_addr;
         lat_wdata <= bus.dbg_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rdata_q <= '0;
      else if (state == ACCESS && !lat_we)
         rdata_q <= bus.rf_rdata1;
   end

   always_comb begin
      state_nxt     = state;
      stall_nxt     = 1'b1;
      bus.rf_wen    = bus.cpu_wen;
      bus.rf_waddr  = bus.cpu_waddr;
      bus.rf_wdata  = bus.cpu_wdata;
      bus.rf_raddr1 = bus.cpu_raddr1;
      bus.dbg_ack   = 1'b0;
      unique case (state)
         INIT: begin
            bus.rf_wen   = 1'b1;
            bus.rf_waddr = cnt;
            bus.rf_wdata = '0;
            if (init_done) begin
               state_nxt = IDLE;
               stall_nxt = 1'b0;
            end
         end
         IDLE: begin
            stall_nxt = bus.dbg_req;
            if (bus.dbg_req)
               state_nxt = STALL;
         end
         STALL: begin
            bus.rf_wen = 1'b0;
            state_nxt  = ACCESS;
         end
         ACCESS: begin
            bus.rf_wen = lat_we;
            if (lat_we) begin
               bus.rf_waddr = lat_addr;
               bus.rf_wdata = lat_wdata;
            end else begin
               bus.rf_raddr1 = lat_addr;
            end
            state_nxt = ACK;
         end
         ACK: begin
            bus.rf_wen  = 1'b0;
            bus.dbg_ack = 1'b1;
            state_nxt   = IDLE;
            stall_nxt   = 1'b0;
         end
         default: begin
            bus.rf_wen = 1'b0;
            state_nxt  = RST_STATE;
         end
      endcase
   end

   assign bus.cpu_stall = stall_q;
   assign bus.dbg_rdata = rdata_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Randomised bench for regfile_ctrl against an abstract register-file model.
// Core writes and debug accesses update a golden array in program order.
module tb_regfile_ctrl;

   localparam int NR = 64;

`ifdef REGFILE_CTRL_INIT_EN
   localparam logic RST_STALL = 1'b1;
`else
   localparam logic RST_STALL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pre = 1'b1;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] seed [NR];
   logic [31:0] mem  [NR];
   logic [31:0] gold [NR];
   logic [31:0] exp_rdata;

   regfile_ctrl_if bus();

   regfile_ctrl #(.NUM_REGS(NR)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Behavioural register file: synchronous write, combinational read
   always @(posedge clk) begin
      if (pre) begin
         for (int i = 0; i < NR; i++) mem[i] <= seed[i];
      end else if (bus.rf_wen) begin
         mem[bus.rf_waddr] <= bus.rf_wdata;
      end
   end

   assign bus.rf_rdata1 = mem[bus.rf_raddr1];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic init_seq();
      for (int i = 0; i < NR; i++) begin
         #1;
         check("init_wen", 32'(bus.rf_wen), 32'd1);
         check("init_waddr", 32'(bus.rf_waddr), 32'(i));
         check("init_wdata", bus.rf_wdata, 32'd0);
         check("init_stall", 32'(bus.cpu_stall), 32'd1);
         tick();
      end
      for (int i = 0; i < NR; i++) gold[i] = 32'd0;
   endtask

   task automatic core_op(input logic w, input logic [5:0] wa,
                          input logic [31:0] wd, input logic [5:0] ra);
      bus.dbg_req    = 1'b0;
      bus.cpu_wen    = w;
      bus.cpu_waddr  = wa;
      bus.cpu_wdata  = wd;
      bus.cpu_raddr1 = ra;
      #1;
      check("idle_stall", 32'(bus.cpu_stall), 32'd0);
      check("idle_ack", 32'(bus.dbg_ack), 32'd0);
      check("pt_wen", 32'(bus.rf_wen), 32'(w));
      check("pt_waddr", 32'(bus.rf_waddr), 32'(wa));
      check("pt_wdata", bus.rf_wdata, wd);
      check("pt_raddr", 32'(bus.rf_raddr1), 32'(ra));
      check("pt_rdata", bus.rf_rdata1, gold[ra]);
      check("rdata_hold", bus.dbg_rdata, exp_rdata);
      if (w) gold[wa] = wd;
      tick();
   endtask

   task automatic dbg_op(input logic we, input logic [5:0] a,
                         input logic [31:0] d, input logic cw,
                         input logic [5:0] ca, input logic [31:0] cd);
      bus.dbg_req    = 1'b1;
      bus.dbg_we     = we;
      bus.dbg_addr   = a;
      bus.dbg_wdata  = d;
      bus.cpu_wen    = cw;
      bus.cpu_waddr  = ca;
      bus.cpu_wdata  = cd;
      bus.cpu_raddr1 = 6'($urandom);
      #1;
      check("req_stall", 32'(bus.cpu_stall), 32'd0);
      check("req_ack", 32'(bus.dbg_ack), 32'd0);
      check("req_cwen", 32'(bus.rf_wen), 32'(cw));
      if (cw) begin
         check("req_cwaddr", 32'(bus.rf_waddr), 32'(ca));
         check("req_cwdata", bus.rf_wdata, cd);
         gold[ca] = cd;
      end
      tick();
      // Scramble the request fields: the access must use the granted ones
      bus.cpu_wen   = 1'b0;
      bus.dbg_we    = ~we;
      bus.dbg_addr  = a ^ 6'h2a;
      bus.dbg_wdata = ~d;
      #1;
      check("c1_stall", 32'(bus.cpu_stall), 32'd1);
      check("c1_wen", 32'(bus.rf_wen), 32'd0);
      check("c1_ack", 32'(bus.dbg_ack), 32'd0);
      tick();
      #1;
      check("c2_stall", 32'(bus.cpu_stall), 32'd1);
      check("c2_ack", 32'(bus.dbg_ack), 32'd0);
      check("c2_wen", 32'(bus.rf_wen), 32'(we));
      if (we) begin
         check("c2_waddr", 32'(bus.rf_waddr), 32'(a));
         check("c2_wdata", bus.rf_wdata, d);
         gold[a] = d;
      end else begin
         check("c2_raddr", 32'(bus.rf_raddr1), 32'(a));
         exp_rdata = gold[a];
      end
      tick();
      bus.dbg_req = 1'b0;
      #1;
      check("c3_ack", 32'(bus.dbg_ack), 32'd1);
      check("c3_stall", 32'(bus.cpu_stall), 32'd1);
      check("c3_wen", 32'(bus.rf_wen), 32'd0);
      check("c3_rdata", bus.dbg_rdata, exp_rdata);
      tick();
   endtask

   task automatic rand_op();
      if ($urandom_range(0, 2) == 0)
         dbg_op(1'($urandom), 6'($urandom), $urandom,
                1'($urandom), 6'($urandom), $urandom);
      else
         core_op(1'($urandom), 6'($urandom), $urandom, 6'($urandom));
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         seed[i] = $urandom;
         gold[i] = seed[i];
      end
      exp_rdata      = 32'd0;
      bus.cpu_wen    = 1'b0;
      bus.cpu_waddr  = '0;
      bus.cpu_wdata  = '0;
      bus.cpu_raddr1 = '0;
      bus.dbg_req    = 1'b0;
      bus.dbg_we     = 1'b0;
      bus.dbg_addr   = '0;
      bus.dbg_wdata  = '0;
      tick();
      pre = 1'b0;
      tick();
      check("rst_stall", 32'(bus.cpu_stall), 32'(RST_STALL));
      check("rst_ack", 32'(bus.dbg_ack), 32'd0);
      check("rst_rdata", bus.dbg_rdata, 32'd0);
      rst = 1'b0;
`ifdef REGFILE_CTRL_INIT_EN
      init_seq();
`endif
      core_op(1'b1, 6'd5, 32'hdeadbeef, 6'd0);
      core_op(1'b0, 6'd0, 32'd0, 6'd5);
      dbg_op(1'b1, 6'd10, 32'h12345678, 1'b0, 6'd0, 32'd0);
      dbg_op(1'b0, 6'd10, 32'd0, 1'b0, 6'd0, 32'd0);
      core_op(1'b0, 6'd0, 32'd0, 6'd10);
      dbg_op(1'b1, 6'd0, 32'hcafef00d, 1'b0, 6'd0, 32'd0);
      dbg_op(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
      dbg_op(1'b0, 6'd3, 32'd0, 1'b1, 6'd3, 32'ha5a5c3c3);
      dbg_op(1'b0, 6'd63, 32'd0, 1'b1, 6'd63, 32'h0badf00d);
      repeat (150) rand_op();

      // Abort a debug write while the core is stalled
      bus.dbg_req   = 1'b1;
      bus.dbg_we    = 1'b1;
      bus.dbg_addr  = 6'd7;
      bus.dbg_wdata = ~gold[7];
      bus.cpu_wen   = 1'b0;
      tick();
      rst         = 1'b1;
      bus.dbg_req = 1'b0;
      #1;
      check("abort_ack", 32'(bus.dbg_ack), 32'd0);
      check("abort_stall", 32'(bus.cpu_stall), 32'(RST_STALL));
      check("abort_rdata", bus.dbg_rdata, 32'd0);
      exp_rdata = 32'd0;
      tick();
      check("abort_ack2", 32'(bus.dbg_ack), 32'd0);
      rst = 1'b0;
`ifdef REGFILE_CTRL_INIT_EN
      init_seq();
`endif
      core_op(1'b0, 6'd0, 32'd0, 6'd7);
      core_op(1'b0, 6'd0, 32'd0, 6'd10);
      repeat (60) rand_op();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
